id_ex_stage: RTL and testbench

//  ID/EX pipeline register with load-use hazard detection for the 5-stage MIPS core.

---
 rtl/id_ex_stage.sv | 110 +++++++++++
 tb/tb_id_ex_stage.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the 5-stage MIPS core: captures decoded operands and controls,
// detects load-use hazards (stall + bubble), squashes on taken branches, counts stall cycles.
module id_ex_stage #(
  parameter int DATA_W  = 32,
  parameter int REG_W   = 5,
  parameter int ALUOP_W = 4,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ID_valid,
  input  logic [REG_W-1:0]   ID_Rs,
  input  logic [REG_W-1:0]   ID_Rt,
  input  logic [REG_W-1:0]   ID_Rd,
  input  logic               ID_usesRs,
  input  logic               ID_usesRt,
  input  logic [DATA_W-1:0]  ID_rdata1,
  input  logic [DATA_W-1:0]  ID_rdata2,
  input  logic [DATA_W-1:0]  ID_imm,
  input  logic               ID_regwrite,
  input  logic               ID_memread,
  input  logic               ID_memwrite,
  input  logic               ID_memtoreg,
  input  logic               ID_regdst,
  input  logic               ID_alusrc,
  input  logic [ALUOP_W-1:0] ID_aluop,
  input  logic               EX_flush,
  output logic               stall,
  output logic               EX_valid,
  output logic [REG_W-1:0]   EX_Rs,
  output logic [REG_W-1:0]   EX_Rt,
  output logic [REG_W-1:0]   EX_writereg,
  output logic [DATA_W-1:0]  EX_rdata1,
  output logic [DATA_W-1:0]  EX_rdata2,
  output logic [DATA_W-1:0]  EX_imm,
  output logic               EX_regwrite,
  output logic               EX_memread,
  output logic               EX_memwrite,
  output logic               EX_memtoreg,
  output logic               EX_alusrc,
  output logic [ALUOP_W-1:0] EX_aluop,
  output logic [CNT_W-1:0]   stall_count
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_ONE;
  endfunction

  logic hz;
  logic rs_match;
  logic rt_match;

  always_comb begin
    rs_match = ID_usesRs && (ID_Rs == EX_writereg);
    rt_match = ID_usesRt && (ID_Rt == EX_writereg);
    hz       = EX_valid && EX_memread && ID_valid && (EX_writereg != '0) && (rs_match || rt_match);
    // A taken branch discards the dependent wrong-path instruction, so no stall is needed
    stall    = hz && !EX_flush && !rst;
  end

  // ID -> EX boundary
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      EX_valid    <= 1'b0;
      EX_Rs       <= '0;
      EX_Rt       <= '0;
      EX_writereg <= '0;
      EX_rdata1   <= '0;
      EX_rdata2   <= '0;
      EX_imm      <= '0;
      EX_regwrite <= 1'b0;
      EX_memread  <= 1'b0;
      EX_memwrite <= 1'b0;
      EX_memtoreg <= 1'b0;
      EX_alusrc   <= 1'b0;
      EX_aluop    <= '0;
    end else if (EX_flush || stall) begin
      // Bubble: only the side-effecting controls are cleared, data fields hold
      EX_valid    <= 1'b0;
      EX_regwrite <= 1'b0;
      EX_memread  <= 1'b0;
      EX_memwrite <= 1'b0;
    end else begin
      EX_valid    <= ID_valid;
      EX_Rs       <= ID_Rs;
      EX_Rt       <= ID_Rt;
      EX_writereg <= ID_regdst ? ID_Rd : ID_Rt;
      EX_rdata1   <= ID_rdata1;
      EX_rdata2   <= ID_rdata2;
      EX_imm      <= ID_imm;
      EX_regwrite <= ID_regwrite && ID_valid;
      EX_memread  <= ID_memread && ID_valid;
      EX_memwrite <= ID_memwrite && ID_valid;
      EX_memtoreg <= ID_memtoreg;
      EX_alusrc   <= ID_alusrc;
      EX_aluop    <= ID_aluop;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_count <= '0;
    end else if (stall) begin
      stall_count <= sat_inc(stall_count);
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: load-use stall, flush priority, capture, saturation, async reset.
module tb_id_ex_stage;
  localparam int DATA_W = 32, REG_W = 5, ALUOP_W = 4, CNT_W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ID_valid, ID_usesRs, ID_usesRt;
  logic [REG_W-1:0] ID_Rs, ID_Rt, ID_Rd;
  logic [DATA_W-1:0] ID_rdata1, ID_rdata2, ID_imm;
  logic ID_regwrite, ID_memread, ID_memwrite, ID_memtoreg, ID_regdst, ID_alusrc;
  logic [ALUOP_W-1:0] ID_aluop;
  logic EX_flush;
  logic stall, EX_valid;
  logic [REG_W-1:0] EX_Rs, EX_Rt, EX_writereg;
  logic [DATA_W-1:0] EX_rdata1, EX_rdata2, EX_imm;
  logic EX_regwrite, EX_memread, EX_memwrite, EX_memtoreg, EX_alusrc;
  logic [ALUOP_W-1:0] EX_aluop;
  logic [CNT_W-1:0] stall_count;

  int vecs = 0;
  int errs = 0;
  int exp_cnt = 0;

  id_ex_stage #(.DATA_W(DATA_W), .REG_W(REG_W), .ALUOP_W(ALUOP_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .ID_valid(ID_valid), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_Rd(ID_Rd),
    .ID_usesRs(ID_usesRs), .ID_usesRt(ID_usesRt), .ID_rdata1(ID_rdata1), .ID_rdata2(ID_rdata2),
    .ID_imm(ID_imm), .ID_regwrite(ID_regwrite), .ID_memread(ID_memread), .ID_memwrite(ID_memwrite),
    .ID_memtoreg(ID_memtoreg), .ID_regdst(ID_regdst), .ID_alusrc(ID_alusrc), .ID_aluop(ID_aluop),
    .EX_flush(EX_flush), .stall(stall), .EX_valid(EX_valid), .EX_Rs(EX_Rs), .EX_Rt(EX_Rt),
    .EX_writereg(EX_writereg), .EX_rdata1(EX_rdata1), .EX_rdata2(EX_rdata2), .EX_imm(EX_imm),
    .EX_regwrite(EX_regwrite), .EX_memread(EX_memread), .EX_memwrite(EX_memwrite),
    .EX_memtoreg(EX_memtoreg), .EX_alusrc(EX_alusrc), .EX_aluop(EX_aluop), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                        input logic urs, input logic urt, input logic rw, input logic mr, input logic mw,
                        input logic mtr, input logic rdst, input logic asrc, input logic [3:0] op,
                        input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm);
    ID_valid = v; ID_Rs = rs; ID_Rt = rt; ID_Rd = rd; ID_usesRs = urs; ID_usesRt = urt;
    ID_regwrite = rw; ID_memread = mr; ID_memwrite = mw; ID_memtoreg = mtr; ID_regdst = rdst;
    ID_alusrc = asrc; ID_aluop = op; ID_rdata1 = d1; ID_rdata2 = d2; ID_imm = imm;
    #1;
  endtask

  task automatic id_nop();
    set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 0, 0, 0);
  endtask

  // lw $rt, 0($rs)
  task automatic id_lw(input logic [4:0] rt, input logic [4:0] rs);
    set_id(1'b1, rs, rt, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4'd0, 32'h100, 0, 0);
  endtask

  // add $rd, $rs, $rt
  task automatic id_add(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [31:0] d1, input logic [31:0] d2);
    set_id(1'b1, rs, rt, rd, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd2, d1, d2, 0);
  endtask

  task automatic test_reset();
    EX_flush = 1'b0;
    id_nop();
    rst = 1'b1;
    tick();
    vecs++; if (stall !== 1'b0) begin errs++; $display("FAIL reset_stall: got %0b want 0", stall); end
    vecs++; if ({EX_valid, EX_Rs, EX_Rt, EX_writereg, EX_rdata1, EX_rdata2, EX_imm, EX_regwrite,
                 EX_memread, EX_memwrite, EX_memtoreg, EX_alusrc, EX_aluop, stall_count} !== '0) begin
      errs++; $display("FAIL reset_outputs: some EX/stall_count output nonzero (valid=%0b cnt=%0d)", EX_valid, stall_count);
    end
    #3 rst = 1'b0;
    tick();
  endtask

  task automatic test_load_use();
    id_lw(5'd2, 5'd1);
    tick();
    id_add(5'd3, 5'd2, 5'd4, 32'h11, 32'h22);
    vecs++; if (stall !== 1'b1) begin errs++; $display("FAIL lu_stall: got %0b want 1", stall); end
    tick();
    exp_cnt++;
    vecs++; if (EX_valid !== 1'b0 || EX_regwrite !== 1'b0 || EX_memread !== 1'b0) begin
      errs++; $display("FAIL lu_bubble: valid=%0b regwrite=%0b memread=%0b want 0 0 0", EX_valid, EX_regwrite, EX_memread);
    end
    vecs++; if (stall !== 1'b0) begin errs++; $display("FAIL lu_stall_drop: got %0b want 0", stall); end
    vecs++; if (stall_count !== 4'(exp_cnt)) begin errs++; $display("FAIL lu_count: got %0d want %0d", stall_count, exp_cnt); end
    tick();
    vecs++; if (EX_valid !== 1'b1 || EX_Rs !== 5'd2 || EX_writereg !== 5'd3) begin
      errs++; $display("FAIL lu_add_in_ex: valid=%0b Rs=%0d wr=%0d want 1 2 3", EX_valid, EX_Rs, EX_writereg);
    end
  endtask

  task automatic test_no_rt_use();
    id_lw(5'd2, 5'd1);
    tick();
    // addi $3,$5,7
    set_id(1'b1, 5'd5, 5'd3, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 32'h55, 0, 32'd7);
    vecs++; if (stall !== 1'b0) begin errs++; $display("FAIL addi_stall: got %0b want 0", stall); end
    tick();
    vecs++; if (EX_valid !== 1'b1 || EX_writereg !== 5'd3 || EX_imm !== 32'd7 || EX_alusrc !== 1'b1) begin
      errs++; $display("FAIL addi_capture: valid=%0b wr=%0d imm=%0d alusrc=%0b want 1 3 7 1", EX_valid, EX_writereg, EX_imm, EX_alusrc);
    end
  endtask

  task automatic test_zero_dest();
    id_lw(5'd0, 5'd1);
    tick();
    id_add(5'd3, 5'd0, 5'd0, 0, 0);
    vecs++; if (stall !== 1'b0) begin errs++; $display("FAIL zero_stall: got %0b want 0", stall); end
    tick();
    vecs++; if (EX_valid !== 1'b1 || EX_writereg !== 5'd3) begin
      errs++; $display("FAIL zero_add_loaded: valid=%0b wr=%0d want 1 3", EX_valid, EX_writereg);
    end
  endtask

  task automatic test_flush_priority();
    id_lw(5'd2, 5'd1);
    tick();
    id_add(5'd3, 5'd2, 5'd2, 0, 0);
    EX_flush = 1'b1;
    #1;
    vecs++; if (stall !== 1'b0) begin errs++; $display("FAIL flush_stall: got %0b want 0", stall); end
    tick();
    EX_flush = 1'b0;
    vecs++; if (EX_valid !== 1'b0 || EX_regwrite !== 1'b0) begin
      errs++; $display("FAIL flush_bubble: valid=%0b regwrite=%0b want 0 0", EX_valid, EX_regwrite);
    end
    vecs++; if (stall_count !== 4'(exp_cnt)) begin errs++; $display("FAIL flush_count: got %0d want %0d", stall_count, exp_cnt); end
  endtask

  task automatic test_rtype_capture();
    id_add(5'd7, 5'd1, 5'd2, 32'hDEADBEEF, 32'h12345678);
    tick();
    vecs++; if (EX_writereg !== 5'd7 || EX_Rs !== 5'd1 || EX_Rt !== 5'd2) begin
      errs++; $display("FAIL rtype_regs: wr=%0d Rs=%0d Rt=%0d want 7 1 2", EX_writereg, EX_Rs, EX_Rt);
    end
    vecs++; if (EX_rdata1 !== 32'hDEADBEEF || EX_rdata2 !== 32'h12345678 || EX_aluop !== 4'd2) begin
      errs++; $display("FAIL rtype_data: d1=%h d2=%h op=%0d want deadbeef 12345678 2", EX_rdata1, EX_rdata2, EX_aluop);
    end
    vecs++; if (EX_regwrite !== 1'b1 || EX_memread !== 1'b0 || EX_valid !== 1'b1) begin
      errs++; $display("FAIL rtype_ctrl: rw=%0b mr=%0b v=%0b want 1 0 1", EX_regwrite, EX_memread, EX_valid);
    end
    // Invalid ID slot with write controls set must not carry them into EX
    set_id(1'b0, 5'd1, 5'd2, 5'd9, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'd3, 0, 0, 0);
    tick();
    vecs++; if (EX_valid !== 1'b0 || EX_regwrite !== 1'b0 || EX_memwrite !== 1'b0 || EX_memread !== 1'b0) begin
      errs++; $display("FAIL invalid_ctrl: v=%0b rw=%0b mw=%0b mr=%0b want 0 0 0 0", EX_valid, EX_regwrite, EX_memwrite, EX_memread);
    end
  endtask

  task automatic test_back_to_back();
    id_lw(5'd2, 5'd1);
    tick();
    id_lw(5'd3, 5'd2);
    vecs++; if (stall !== 1'b1) begin errs++; $display("FAIL b2b_stall1: got %0b want 1", stall); end
    tick();
    exp_cnt++;
    vecs++; if (stall !== 1'b0) begin errs++; $display("FAIL b2b_bubble: got %0b want 0", stall); end
    tick();
    id_add(5'd4, 5'd3, 5'd3, 0, 0);
    vecs++; if (stall !== 1'b1) begin errs++; $display("FAIL b2b_stall2: got %0b want 1", stall); end
    tick();
    exp_cnt++;
    vecs++; if (stall_count !== 4'(exp_cnt)) begin errs++; $display("FAIL b2b_count: got %0d want %0d", stall_count, exp_cnt); end
    tick();
  endtask

  task automatic test_saturate_and_reset();
    bit exp_stall;
    id_nop();
    tick();
    // lw $2,0($2): self-dependent load stalls every other cycle
    id_lw(5'd2, 5'd2);
    for (int i = 0; i < 40; i++) begin
      exp_stall = (i % 2) == 1;
      vecs++; if (stall !== exp_stall) begin errs++; $display("FAIL sat_stall_%0d: got %0b want %0b", i, stall, exp_stall); end
      tick();
      if (exp_stall && exp_cnt < 15) exp_cnt++;
    end
    vecs++; if (stall_count !== 4'd15) begin errs++; $display("FAIL sat_count: got %0d want 15", stall_count); end
    tick();
    vecs++; if (stall !== 1'b1) begin errs++; $display("FAIL pre_reset_stall: got %0b want 1", stall); end
    #2 rst = 1'b1;
    #1;
    vecs++; if (stall !== 1'b0) begin errs++; $display("FAIL async_rst_stall: got %0b want 0", stall); end
    vecs++; if ({EX_valid, EX_Rs, EX_Rt, EX_writereg, EX_rdata1, EX_rdata2, EX_imm, EX_regwrite,
                 EX_memread, EX_memwrite, EX_memtoreg, EX_alusrc, EX_aluop, stall_count} !== '0) begin
      errs++; $display("FAIL async_rst_outputs: valid=%0b memread=%0b cnt=%0d want all 0", EX_valid, EX_memread, stall_count);
    end
    #1 rst = 1'b0;
    id_add(5'd7, 5'd1, 5'd2, 32'hA5, 32'h5A);
    tick();
    vecs++; if (EX_valid !== 1'b1 || EX_writereg !== 5'd7 || EX_rdata1 !== 32'hA5 || stall_count !== 4'd0) begin
      errs++; $display("FAIL post_reset_load: v=%0b wr=%0d d1=%h cnt=%0d want 1 7 a5 0", EX_valid, EX_writereg, EX_rdata1, stall_count);
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_no_rt_use();
    test_zero_dest();
    test_flush_priority();
    test_rtype_capture();
    test_back_to_back();
    test_saturate_and_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end
endmodule
